// File: rtl/vga_pkg.sv
// Shared VGA definitions: default timing constants, the RGB444 pixel type
// and the scanline feeder state encoding.
package vga_pkg;
  localparam int          H_ACTIVE = 1024;
  localparam int          V_ACTIVE = 768;
  localparam logic [15:0] STB_INC  = 16'hA666;

  typedef logic [11:0] rgb444_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAG,
    ST_WRITE,
    ST_HOLD
  } feed_state_t;
endpackage

// File: rtl/scanline_feeder_if.sv
// Pixel stream between the renderer and the scanline feeder.
//   pix_valid / pix_data / pix_last : renderer -> feeder
//   pix_ready                       : feeder -> renderer
// master = renderer side, slave = feeder side.
interface scanline_feeder_if;
  import vga_pkg::*;
  logic    pix_valid;
  rgb444_t pix_data;
  logic    pix_last;
  logic    pix_ready;

  modport master (output pix_valid, pix_data, pix_last, input pix_ready);
  modport slave  (input pix_valid, pix_data, pix_last, output pix_ready);
endinterface

// File: rtl/pix_strobe.sv
// Pixel-slot strobe: fractional accumulator whose carry-out marks a pixel
// slot (STB_INC/65536 of clock cycles).
//   clk_i  : system clock
//   rst_ni : async active-low reset
//   stb_o  : one-cycle strobe, registered
module pix_strobe #(
  parameter logic [15:0] STB_INC = vga_pkg::STB_INC
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic stb_o
);
  logic [15:0] acc_q, acc_d;
  logic        stb_q, stb_d;

  assign {stb_d, acc_d} = {1'b0, acc_q} + {1'b0, STB_INC};
  assign stb_o = stb_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      stb_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      stb_q <= stb_d;
    end
  end
endmodule

// File: rtl/scanline_feeder.sv
// Scanline feeder: writes one renderer pixel per pixel slot into the
// single-line VRAM of VGA_output, trailing the read beam by LAG_PIX slots.
//   CLK, RST_N       : clock, async active-low reset
//   LINEEND_IN       : high during horizontal blanking; falling edge = line start
//   VS_IN            : active-low vsync, restarts the frame at y=0
//   pix              : valid/ready RGB444 pixel stream (slave side)
//   x, y, data_out   : VRAM write address, current line, write data
//   underrun         : sticky, a write slot found no pixel
//   sync_err         : sticky, pix_last disagreed with the line position
//   clr_err          : synchronous clear of both sticky flags
module scanline_feeder #(
  parameter int          H_ACTIVE       = vga_pkg::H_ACTIVE,
  parameter int          V_ACTIVE       = vga_pkg::V_ACTIVE,
  parameter logic [15:0] STB_INC        = vga_pkg::STB_INC,
  parameter int          LAG_PIX        = 4,
  parameter logic [11:0] UNDERRUN_COLOR = 12'h000
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                LINEEND_IN,
  input  logic                VS_IN,
  scanline_feeder_if.slave    pix,
  output logic [10:0]         x,
  output logic [11:0]         y,
  output logic [11:0]         data_out,
  output logic                underrun,
  output logic                sync_err,
  input  logic                clr_err
);
  import vga_pkg::*;

  feed_state_t state_q, state_d;
  logic        stb, le_q, ls, slot, last_slot, last_line;
  logic [3:0]  lag_q, lag_d;
  logic [10:0] xc_q, xc_d, x_q, x_d;
  logic [11:0] y_q, y_d;
  rgb444_t     data_q, data_d;
  logic        unr_q, unr_d, serr_q, serr_d;

  pix_strobe #(.STB_INC(STB_INC)) u_stb (
    .clk_i (CLK),
    .rst_ni(RST_N),
    .stb_o (stb)
  );

  assign ls        = le_q & ~LINEEND_IN;
  assign slot      = (state_q == ST_WRITE) & stb;
  assign last_slot = (xc_q == 11'(H_ACTIVE - 1));
  assign last_line = (y_q == 12'(V_ACTIVE - 1));

  assign pix.pix_ready = slot;
  assign x        = x_q;
  assign y        = y_q;
  assign data_out = data_q;
  assign underrun = unr_q;
  assign sync_err = serr_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      le_q    <= 1'b0;
      lag_q   <= '0;
      xc_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= '0;
      unr_q   <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      le_q    <= LINEEND_IN;
      lag_q   <= lag_d;
      xc_q    <= xc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      data_q  <= data_d;
      unr_q   <= unr_d;
      serr_q  <= serr_d;
    end
  end

  // The lag counter is preloaded with LAG_PIX-1 and LAG is left on the
  // strobe that empties it, so the LAG_PIX-th strobe after line start is
  // already the first write slot. LAG_PIX==1 skips LAG entirely.
  always_comb begin
    state_d = state_q;
    if (!VS_IN) state_d = ST_IDLE;
    else begin
      case (state_q)
        ST_IDLE:  if (ls) state_d = (LAG_PIX == 1) ? ST_WRITE : ST_LAG;
        ST_LAG:   if (stb && lag_q == 4'd1) state_d = ST_WRITE;
        ST_WRITE: if (slot && last_slot) state_d = last_line ? ST_HOLD : ST_IDLE;
        default:  ;
      endcase
    end
  end

  // Datapath. Vsync dominates: the line is abandoned, x/data_out hold.
  always_comb begin
    lag_d  = lag_q;
    xc_d   = xc_q;
    x_d    = x_q;
    y_d    = y_q;
    data_d = data_q;
    unr_d  = unr_q;
    serr_d = serr_q;
    // clear first so a same-cycle set below wins
    if (clr_err) begin
      unr_d  = 1'b0;
      serr_d = 1'b0;
    end
    if (!VS_IN) y_d = '0;
    else begin
      case (state_q)
        ST_IDLE: if (ls) begin
          lag_d = 4'(LAG_PIX - 1);
          xc_d  = '0;
        end
        ST_LAG: if (stb) lag_d = lag_q - 4'd1;
        ST_WRITE: if (stb) begin
          x_d  = xc_q;
          xc_d = last_slot ? 11'd0 : xc_q + 11'd1;
          if (pix.pix_valid) begin
            data_d = pix.pix_data;
            if (pix.pix_last != last_slot) serr_d = 1'b1;
          end else begin
            data_d = UNDERRUN_COLOR;
            unr_d  = 1'b1;
          end
          if (last_slot && !last_line) y_d = y_q + 12'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_scanline_feeder.sv
module tb_scanline_feeder;
  import vga_pkg::*;

  localparam int          HA  = 64;
  localparam int          VA  = 6;
  localparam int          LAG = 4;
  localparam logic [15:0] INC = 16'hA666;
  localparam logic [11:0] UND = 12'h000;

  logic        CLK = 1'b0, RST_N = 1'b0, LINEEND_IN = 1'b0, VS_IN = 1'b1, clr_err = 1'b0;
  logic [10:0] x;
  logic [11:0] y, data_out;
  logic        underrun, sync_err;

  scanline_feeder_if pix();

  scanline_feeder #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .STB_INC(INC), .LAG_PIX(LAG), .UNDERRUN_COLOR(UND)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .LINEEND_IN(LINEEND_IN), .VS_IN(VS_IN), .pix(pix),
    .x(x), .y(y), .data_out(data_out), .underrun(underrun), .sync_err(sync_err),
    .clr_err(clr_err)
  );

  always #5 CLK = ~CLK;

  // reference pixel strobe
  logic [15:0] acc_m;
  logic        stb_m;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_m <= '0;
      stb_m <= 1'b0;
    end else {stb_m, acc_m} <= {1'b0, acc_m} + {1'b0, INC};
  end

  typedef struct { logic [11:0] d; logic last; } px_t;
  typedef struct { logic [10:0] x; logic [11:0] d; } wr_t;
  px_t src_q[$];
  wr_t exp_q[$];

  int n_chk = 0, n_fail = 0;
  int slot_x = 0, gap_lo = -1, gap_hi = -1, nwr = 0, nrdy = 0, lag_stb = 0;
  bit lag_arm = 0, wr_pend = 0, rdy_now = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [11:0] base, input int n, input int last_idx);
    px_t p;
    for (int k = 0; k < n; k++) begin
      p.d    = base + 12'(k);
      p.last = (k == last_idx);
      src_q.push_back(p);
    end
  endtask

  // One clock: check the write produced by last cycle's slot, drive the
  // source for this cycle, and book the expected write if this is a slot.
  task automatic cyc(input int n = 1);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      if (wr_pend) begin
        e = exp_q.pop_front();
        chk("wr_x", 32'(x), 32'(e.x));
        chk("wr_data", 32'(data_out), 32'(e.d));
        nwr++;
        wr_pend = 0;
      end
      pix.pix_valid = (src_q.size() > 0) && !(slot_x >= gap_lo && slot_x <= gap_hi);
      pix.pix_data  = pix.pix_valid ? src_q[0].d : 12'h0;
      pix.pix_last  = pix.pix_valid ? src_q[0].last : 1'b0;
      rdy_now = pix.pix_ready;
      if (lag_arm && stb_m) lag_stb++;
      if (rdy_now) begin
        nrdy++;
        chk("rdy_on_stb", 32'(stb_m), 1);
        if (lag_arm) begin
          chk("first_slot_stb", lag_stb, LAG);
          lag_arm = 0;
        end
        e.x = 11'(slot_x);
        if (pix.pix_valid) begin
          e.d = src_q[0].d;
          void'(src_q.pop_front());
        end else e.d = UND;
        exp_q.push_back(e);
        wr_pend = 1;
        slot_x++;
      end
    end
  endtask

  task automatic line_start();
    LINEEND_IN = 1'b1;
    cyc(2);
    LINEEND_IN = 1'b0;
    slot_x = 0; nwr = 0; lag_arm = 1; lag_stb = 0;
  endtask

  task automatic wait_line(input string tag);
    int t = 0;
    while (nwr < HA && t < 400) begin cyc(1); t++; end
    cyc(3);
    chk({tag, "_writes"}, nwr, HA);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, n0;
    logic [10:0] last_x;
    pix.pix_valid = 1'b0; pix.pix_data = '0; pix.pix_last = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_ready", 32'(pix.pix_ready), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_sync_err", 32'(sync_err), 0);
    RST_N = 1'b1;
    cyc(5);

    // clean line, data_out == x
    load(12'h000, HA, HA - 1);
    line_start();
    wait_line("l0");
    chk("l0_y", 32'(y), 1);
    chk("l0_underrun", 32'(underrun), 0);
    chk("l0_sync_err", 32'(sync_err), 0);
    chk("l0_consumed", src_q.size(), 0);

    // underrun gap at slots 10..12; held pixel lands at 13
    load(12'h100, HA - 3, HA - 4);
    gap_lo = 10; gap_hi = 12;
    line_start();
    wait_line("l1");
    gap_lo = -1; gap_hi = -1;
    chk("l1_y", 32'(y), 2);
    chk("l1_underrun", 32'(underrun), 1);
    chk("l1_sync_err", 32'(sync_err), 0);
    chk("l1_consumed", src_q.size(), 0);
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    chk("clr_underrun", 32'(underrun), 0);

    // misplaced pix_last
    load(12'h200, HA, 50);
    line_start();
    wait_line("l2");
    chk("l2_sync_err", 32'(sync_err), 1);
    chk("l2_y", 32'(y), 3);

    // vsync in the middle of a line
    load(12'h300, HA, HA - 1);
    line_start();
    t = 0;
    while (!(slot_x > 30 && !rdy_now) && t < 500) begin cyc(1); t++; end
    chk("vs_reach", 32'(slot_x > 30), 1);
    last_x = 11'(slot_x - 1);
    VS_IN = 1'b0;
    n0 = nrdy;
    cyc(3);
    VS_IN = 1'b1;
    cyc(100);
    chk("vs_no_slots", nrdy - n0, 0);
    chk("vs_y", 32'(y), 0);
    chk("vs_x_hold", 32'(x), 32'(last_x));
    src_q.delete();
    load(12'h400, HA, HA - 1);
    line_start();
    wait_line("vs_restart");
    chk("vs_restart_y", 32'(y), 1);

    // full frame, then HOLD
    VS_IN = 1'b0;
    cyc(2);
    VS_IN = 1'b1;
    cyc(2);
    chk("frame_y0", 32'(y), 0);
    for (int l = 0; l < VA; l++) begin
      load(12'(l * 16), HA, HA - 1);
      line_start();
      wait_line("frame");
      chk("frame_y", 32'(y), (l + 1 < VA - 1) ? l + 1 : VA - 1);
    end
    n0 = nrdy;
    line_start();
    cyc(200);
    chk("hold_no_slots", nrdy - n0, 0);
    chk("hold_y", 32'(y), VA - 1);
    VS_IN = 1'b0;
    cyc(2);
    VS_IN = 1'b1;
    cyc(2);
    chk("hold_vs_y", 32'(y), 0);
    load(12'h500, HA, HA - 1);
    line_start();
    wait_line("after_hold");
    chk("after_hold_y", 32'(y), 1);

    // reset in the middle of a line
    chk("pre_rst_sync_err", 32'(sync_err), 1);
    load(12'h600, HA, HA - 1);
    line_start();
    t = 0;
    while (slot_x < 20 && t < 500) begin cyc(1); t++; end
    chk("rst_reach", 32'(slot_x >= 20), 1);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_x", 32'(x), 0);
    chk("mid_rst_y", 32'(y), 0);
    chk("mid_rst_data", 32'(data_out), 0);
    chk("mid_rst_ready", 32'(pix.pix_ready), 0);
    chk("mid_rst_underrun", 32'(underrun), 0);
    chk("mid_rst_sync_err", 32'(sync_err), 0);
    exp_q.delete(); src_q.delete();
    wr_pend = 0; lag_arm = 0;
    @(negedge CLK);
    RST_N = 1'b1;
    n0 = nrdy;
    cyc(100);
    chk("post_rst_no_slots", nrdy - n0, 0);
    chk("post_rst_x", 32'(x), 0);
    load(12'h700, HA, HA - 1);
    line_start();
    wait_line("post_rst");
    chk("post_rst_y", 32'(y), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
